// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending transaction controller.
//   vend_state_t   : top-level FSM states
//   COIN_SEL_*     : coin_sel encodings driven to the change hopper
//   COIN_*         : coin values in cents
//   DEF_*          : default parameter values (prices, widths, timeout)
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_VEND,
    ST_CHANGE,
    ST_CLEAR
  } vend_state_t;

  localparam logic [1:0] COIN_SEL_NONE = 2'b00;
  localparam logic [1:0] COIN_SEL_5    = 2'b01;
  localparam logic [1:0] COIN_SEL_10   = 2'b10;
  localparam logic [1:0] COIN_SEL_25   = 2'b11;

  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_25 = 25;

  localparam int unsigned DEF_CREDIT_W     = 7;
  localparam int unsigned DEF_PRICE_0      = 50;
  localparam int unsigned DEF_PRICE_1      = 65;
  localparam int unsigned DEF_PRICE_2      = 75;
  localparam int unsigned DEF_PRICE_3      = 100;
  localparam int unsigned DEF_VEND_TIMEOUT = 255;

endpackage

// File: rtl/vend_sequencer_change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time, greedy
// largest-coin-first, through a req/ack handshake with the coin hopper.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_load          : load i_load_val into the remaining-change register
//   i_load_val      : change amount in cents
//   i_start         : high while the owner is in its change-paying state
//   i_coin_ack      : one-cycle pulse, requested coin ejected
//   o_coin_req      : coin request to hopper
//   o_coin_sel      : coin type (stable while o_coin_req is high)
//   o_done          : remaining change below the smallest coin
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = DEF_CREDIT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_load_val,
  input  logic                i_start,
  input  logic                i_coin_ack,
  output logic                o_coin_req,
  output logic [1:0]          o_coin_sel,
  output logic                o_done
);

  logic [CREDIT_W-1:0] r_change;
  logic                r_gap;      // forces one idle cycle after each ack
  logic [CREDIT_W-1:0] w_coin_val;

  always_comb begin
    o_coin_req = 1'b0;
    o_coin_sel = COIN_SEL_NONE;
    o_done     = 1'b0;
    w_coin_val = '0;
    if (i_start) begin
      if (r_change < CREDIT_W'(COIN_5)) begin
        o_done = 1'b1;
      end else if (!r_gap) begin
        o_coin_req = 1'b1;
        if (r_change >= CREDIT_W'(COIN_25)) begin
          o_coin_sel = COIN_SEL_25;
          w_coin_val = CREDIT_W'(COIN_25);
        end else if (r_change >= CREDIT_W'(COIN_10)) begin
          o_coin_sel = COIN_SEL_10;
          w_coin_val = CREDIT_W'(COIN_10);
        end else begin
          o_coin_sel = COIN_SEL_5;
          w_coin_val = CREDIT_W'(COIN_5);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_change <= '0;
      r_gap    <= 1'b0;
    end else if (i_load) begin
      r_change <= i_load_val;
      r_gap    <= 1'b0;
    end else begin
      r_gap <= 1'b0;
      if (o_coin_req && i_coin_ack) begin
        r_change <= r_change - w_coin_val;
        r_gap    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine transaction controller.
//   clk, reset_n   : clock, asynchronous active-low reset
//   credit         : running credit from the coin accumulator
//   select         : item buttons, lowest set index wins
//   vend_req/item  : dispense request and item index to motor driver
//   vend_ack       : one-cycle pulse, item dropped
//   coin_req/sel   : change-coin request and coin type to hopper
//   coin_ack       : one-cycle pulse, coin ejected
//   clear_credit   : one-cycle pulse zeroing the accumulator
//   busy           : transaction in progress
//   deny           : one-cycle pulse, insufficient credit
//   fault          : one-cycle pulse, vend timeout (full refund follows)
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W     = DEF_CREDIT_W,
  parameter int unsigned PRICE_0      = DEF_PRICE_0,
  parameter int unsigned PRICE_1      = DEF_PRICE_1,
  parameter int unsigned PRICE_2      = DEF_PRICE_2,
  parameter int unsigned PRICE_3      = DEF_PRICE_3,
  parameter int unsigned VEND_TIMEOUT = DEF_VEND_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [3:0]          select,
  output logic                vend_req,
  output logic [1:0]          vend_item,
  input  logic                vend_ack,
  output logic                coin_req,
  output logic [1:0]          coin_sel,
  input  logic                coin_ack,
  output logic                clear_credit,
  output logic                busy,
  output logic                deny,
  output logic                fault
);

  localparam int unsigned TMR_W = $clog2(VEND_TIMEOUT + 1);

  vend_state_t         r_state, w_next;
  logic [1:0]          r_item;
  logic [CREDIT_W-1:0] r_snap;
  logic [TMR_W-1:0]    r_timer;

  logic [1:0]          w_sel_idx;
  logic [CREDIT_W-1:0] w_price;
  logic                w_load;
  logic [CREDIT_W-1:0] w_load_val;
  logic                w_active;
  logic                w_done;

  always_comb begin
    w_sel_idx = 2'd0;
    if      (select[0]) w_sel_idx = 2'd0;
    else if (select[1]) w_sel_idx = 2'd1;
    else if (select[2]) w_sel_idx = 2'd2;
    else if (select[3]) w_sel_idx = 2'd3;
  end

  always_comb begin
    case (r_item)
      2'd0:    w_price = CREDIT_W'(PRICE_0);
      2'd1:    w_price = CREDIT_W'(PRICE_1);
      2'd2:    w_price = CREDIT_W'(PRICE_2);
      default: w_price = CREDIT_W'(PRICE_3);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_item  <= '0;
      r_snap  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && |select) begin
        r_item <= w_sel_idx;
        r_snap <= credit;
      end
      r_timer <= (r_state == ST_VEND) ? r_timer + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    vend_req     = 1'b0;
    vend_item    = '0;
    clear_credit = 1'b0;
    deny         = 1'b0;
    fault        = 1'b0;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_active     = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (|select) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_snap >= w_price) begin
          w_load     = 1'b1;
          w_load_val = r_snap - w_price;
          w_next     = ST_VEND;
        end else begin
          deny   = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_VEND: begin
        vend_req  = 1'b1;
        vend_item = r_item;
        // ack takes precedence over a timeout landing in the same cycle
        if (vend_ack) begin
          w_next = ST_CHANGE;
        end else if (r_timer == TMR_W'(VEND_TIMEOUT - 1)) begin
          fault      = 1'b1;
          w_load     = 1'b1;
          w_load_val = r_snap;
          w_next     = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        w_active = 1'b1;
        if (w_done) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        clear_credit = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_start    (w_active),
    .i_coin_ack (coin_ack),
    .o_coin_req (coin_req),
    .o_coin_sel (coin_sel),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] credit = '0;
  logic [3:0] select = '0;
  logic       vend_ack = 1'b0;
  logic       coin_ack = 1'b0;
  logic       vend_req, coin_req, clear_credit, busy, deny, fault;
  logic [1:0] vend_item, coin_sel;

  int n_cmp = 0;
  int n_err = 0;

  vend_sequencer #(
    .CREDIT_W     (7),
    .PRICE_0      (50),
    .PRICE_1      (65),
    .PRICE_2      (75),
    .PRICE_3      (100),
    .VEND_TIMEOUT (255)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .credit       (credit),
    .select       (select),
    .vend_req     (vend_req),
    .vend_item    (vend_item),
    .vend_ack     (vend_ack),
    .coin_req     (coin_req),
    .coin_sel     (coin_sel),
    .coin_ack     (coin_ack),
    .clear_credit (clear_credit),
    .busy         (busy),
    .deny         (deny),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // coins: expected coin_sel sequence, coin i in bits [2i+1:2i]
  task automatic run_txn(input string name, input logic [6:0] cr, input logic [3:0] sel,
                         input int ack_dly, input bit exp_deny, input int exp_item,
                         input int ncoins, input logic [7:0] coins);
    int cnt;
    logic [1:0] exp_sel;
    credit = cr;
    select = sel;
    step();
    select = '0;
    check_val({name, "/check_busy"}, 32'(busy), 1);
    check_val({name, "/check_deny"}, 32'(deny), 32'(exp_deny));
    check_val({name, "/check_vreq"}, 32'(vend_req), 0);
    if (exp_deny) begin
      step();
      check_val({name, "/deny_end"}, 32'(deny), 0);
      check_val({name, "/deny_idle"}, 32'(busy), 0);
      check_val({name, "/deny_noclr"}, 32'(clear_credit), 0);
      step();
      check_val({name, "/deny_novreq"}, 32'(vend_req), 0);
      return;
    end
    step();
    check_val({name, "/vend_req"}, 32'(vend_req), 1);
    check_val({name, "/vend_item"}, 32'(vend_item), 32'(exp_item));
    if (ack_dly >= 0) begin
      repeat (ack_dly) step();
      check_val({name, "/vreq_hold"}, 32'(vend_req), 1);
      vend_ack = 1'b1;
      check_val({name, "/no_fault"}, 32'(fault), 0);
      step();
      vend_ack = 1'b0;
    end else begin
      cnt = 1;
      while (!fault && cnt < 300) begin
        step();
        cnt++;
      end
      check_val({name, "/fault"}, 32'(fault), 1);
      check_val({name, "/fault_cycle"}, 32'(cnt), 255);
      step();
      check_val({name, "/fault_end"}, 32'(fault), 0);
    end
    check_val({name, "/first_creq"}, 32'(coin_req), 32'(ncoins > 0));
    for (int i = 0; i < ncoins; i++) begin
      exp_sel = coins[2*i +: 2];
      cnt = 0;
      while (!coin_req && cnt < 10) begin
        step();
        cnt++;
      end
      check_val({name, "/coin_req"}, 32'(coin_req), 1);
      check_val({name, "/coin_sel"}, 32'(coin_sel), 32'(exp_sel));
      step();
      check_val({name, "/coin_hold"}, 32'(coin_sel), 32'(exp_sel));
      coin_ack = 1'b1;
      step();
      coin_ack = 1'b0;
      check_val({name, "/coin_gap"}, 32'(coin_req), 0);
    end
    check_val({name, "/pre_clr"}, 32'(clear_credit), 0);
    step();
    check_val({name, "/clear"}, 32'(clear_credit), 1);
    check_val({name, "/clr_creq"}, 32'(coin_req), 0);
    step();
    check_val({name, "/clr_end"}, 32'(clear_credit), 0);
    check_val({name, "/idle"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_val("rst/vend_req", 32'(vend_req), 0);
    check_val("rst/vend_item", 32'(vend_item), 0);
    check_val("rst/coin_req", 32'(coin_req), 0);
    check_val("rst/coin_sel", 32'(coin_sel), 0);
    check_val("rst/clear", 32'(clear_credit), 0);
    check_val("rst/busy", 32'(busy), 0);
    check_val("rst/deny", 32'(deny), 0);
    check_val("rst/fault", 32'(fault), 0);
    reset_n = 1'b1;
    step();

    run_txn("exact50",   7'd50,  4'b0001, 3,  1'b0, 0, 0, 8'b0);
    run_txn("c100_i2",   7'd100, 4'b0100, 1,  1'b0, 2, 1, 8'b11);
    run_txn("c85_i1",    7'd85,  4'b0010, 2,  1'b0, 1, 2, 8'b10_10);
    run_txn("short40",   7'd40,  4'b0001, 0,  1'b1, 0, 0, 8'b0);
    run_txn("prio1011",  7'd60,  4'b1011, 0,  1'b0, 0, 1, 8'b10);
    run_txn("timeout70", 7'd70,  4'b0001, -1, 1'b0, 0, 4, 8'b10_10_11_11);
    run_txn("c127_i3",   7'd127, 4'b1000, 4,  1'b0, 3, 1, 8'b11);
    run_txn("short99",   7'd99,  4'b1000, 0,  1'b1, 3, 0, 8'b0);
    run_txn("c90_i1",    7'd90,  4'b0010, 1,  1'b0, 1, 1, 8'b11);

    // reset mid-CHANGE: everything drops at once, no clear_credit
    credit = 7'd100;
    select = 4'b0100;
    step();
    select = '0;
    step();
    vend_ack = 1'b1;
    step();
    vend_ack = 1'b0;
    check_val("mid/coin_req", 32'(coin_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid/rst_creq", 32'(coin_req), 0);
    check_val("mid/rst_csel", 32'(coin_sel), 0);
    check_val("mid/rst_busy", 32'(busy), 0);
    check_val("mid/rst_clr", 32'(clear_credit), 0);
    step();
    check_val("mid/hold_clr", 32'(clear_credit), 0);
    reset_n = 1'b1;
    step();
    check_val("mid/post_busy", 32'(busy), 0);
    check_val("mid/post_clr", 32'(clear_credit), 0);
    check_val("mid/post_creq", 32'(coin_req), 0);

    run_txn("after_rst", 7'd75, 4'b0100, 2, 1'b0, 2, 0, 8'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Top-level transaction controller for the retro vending machine.
- Accepts product selections and checks the coin accumulator's running credit against a per-item price.
- Sequences the dispense-motor handshake, then pays out change one coin at a time through a coin-hopper handshake.
- Clears the accumulator when the transaction ends. Sits between the front-panel buttons, the coin accumulator, the motor driver and the change hopper.

Parameters:
- CREDIT_W, 7, width of credit/price/change arithmetic (max 127 cents).
- PRICE_0, 50, price of item 0 in cents.
- PRICE_1, 65, price of item 1 in cents.
- PRICE_2, 75, price of item 2 in cents.
- PRICE_3, 100, price of item 3 in cents.
- VEND_TIMEOUT, 255, cycles to wait for vend_ack before declaring a motor fault.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- credit  in  CREDIT_W  running total from the coin accumulator.
- select  in  4  item request buttons, bit i = item i, level-sampled.
- vend_req  out  1  dispense request to motor driver.
- vend_item  out  2  item index, valid while vend_req=1.
- vend_ack  in  1  one-cycle pulse: item dropped.
- coin_req  out  1  change-coin request to hopper.
- coin_sel  out  2  coin type: 01=5c, 10=10c, 11=25c; 00 when idle.
- coin_ack  in  1  one-cycle pulse: requested coin ejected.
- clear_credit  out  1  one-cycle pulse zeroing the accumulator.
- busy  out  1  high in any state other than IDLE.
- deny  out  1  one-cycle pulse: selection refused (insufficient credit).
- fault  out  1  one-cycle pulse: vend timeout.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; internal item, latched credit, change and timer registers 0. Reset mid-transaction aborts immediately; no coin is paid and credit is not cleared.
- States: IDLE, CHECK, VEND, CHANGE, CLEAR.
- IDLE:
  - If any select bit is set, the lowest set index wins (fixed priority). Register the item and snapshot credit.
  - Go to CHECK on the next edge. Later button changes are ignored until the return to IDLE.
- CHECK (one cycle):
  - If snapshot >= price[item]: change = snapshot - price (CREDIT_W bits, no underflow possible). Go to VEND.
  - Else: pulse deny for one cycle, go to IDLE, leave credit untouched.
- VEND:
  - vend_req=1 and vend_item=item, held until vend_ack. A timer counts cycles in VEND.
  - On vend_ack: go to CHANGE.
  - If the timer reaches VEND_TIMEOUT with no ack: pulse fault, set change = full snapshot (refund), go to CHANGE.
  - If vend_ack and timeout occur in the same cycle, ack wins.
- CHANGE:
  - If change < 5: go to CLEAR. A residual of 1-4c is forfeited.
  - Else coin_req=1 with greedy coin_sel: 11 if change >= 25, else 10 if change >= 10, else 01.
  - coin_sel is stable while coin_req=1.
  - On coin_ack, subtract the coin value and re-evaluate next cycle. coin_req deasserts for at least one cycle between coins.
  - coin_ack outside CHANGE is ignored.
- CLEAR: pulse clear_credit for exactly one cycle, go to IDLE.
- Coins inserted during a transaction are not added to the snapshot. They are lost at CLEAR; the accumulator owns that policy.
- Latency:
  - select to vend_req: 2 cycles.
  - vend_ack to first coin_req: 1 cycle.
  - Last coin_ack to clear_credit: 2 cycles (re-evaluate, then CLEAR).

Decomposition:
- Shared package vend_pkg holds:
  - state enum.
  - coin_sel encodings plus COIN_5/10/25 value constants.
  - default price constants.
- One natural sub-module: change_dispenser. It owns the greedy coin selection, the remaining-change register and the coin_req/coin_ack handshake. It takes a load value and a start input and returns done.
- Priority select and the price mux stay in the top-level FSM.

Test Plan:
- credit=50, select=0001, vend_ack 3 cycles after vend_req -> vend_item=0, no coin_req, clear_credit pulse, back to IDLE.
- credit=100, select=0100 (75c) -> vend_item=2, then one coin_sel=11 cycle pair, clear_credit after its ack.
- credit=85, select=0010 (65c) -> coin sequence 10, 10 (20c), then clear_credit.
- credit=40, select=0001 -> deny pulse 1 cycle after CHECK, no vend_req, no clear_credit.
- credit=60, select=1011 -> item 0 chosen (lowest index), change=10 paid as one 10c coin.
- credit=70, select=0001, vend_ack never arrives -> fault pulse at cycle 255 of VEND, refund 25, 25, 10, 10 (70c), then clear_credit.
- Reset_n asserted mid-CHANGE -> all outputs 0 asynchronously, state IDLE, no clear_credit.
